ksa_multiword_seq: RTL and testbench
====================================

Name: ksa_multiword_seq

Overview:
- Sequencer that performs NWORDS*16-bit add/subtract by time-multiplexing one 16-bit Kogge-Stone adder.
- Processes one 16-bit slice per cycle, least-significant slice first, chaining carry through a register.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Gives wide-operand arithmetic without replicating the adder tree.

Parameters:
- WORD_W, 16, slice width; fixed to the Kogge-Stone adder width; other values unsupported.
- NWORDS, 4, number of slices per operation; legal range 1..16.
- OP_W, WORD_W*NWORDS, operand/result width; derived, not overridable.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request.
- a  input  OP_W  operand A.
- b  input  OP_W  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  OP_W  result.
- cout  output  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- ovf  output  1  signed (two's complement) overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset state: state=IDLE, out_valid=0, sum=0, cout=0, ovf=0, busy=0, slice index=0, carry reg=0.
- in_ready is forced 0 while rst=1.
- States: IDLE, RUN, DONE. in_ready=1 only in IDLE.
- IDLE:
  - Accept on in_valid && in_ready.
  - Capture a and beff (b, or ~b if sub).
  - Load carry reg with (sub ? 1 : cin). Set idx=0. Go to RUN.
- RUN (one slice per cycle):
  - Adder inputs: a[idx], beff[idx], carry reg.
  - Register the adder s into sum slice idx; carry reg <= adder cout; idx <= idx+1.
  - On the cycle idx==NWORDS-1:
    - also register cout <= adder cout;
    - ovf <= (a_msb == beff_msb) && (s_msb != a_msb);
    - go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf held stable.
  - On out_ready: out_valid <= 0, go to IDLE.
  - in_valid is ignored in RUN and DONE; no requests are queued.
- Latency:
  - Accept on edge k → out_valid high after edge k+NWORDS.
  - Minimum initiation interval is NWORDS+2 cycles (one DONE cycle with out_ready=1, one IDLE cycle).
- NWORDS=1: RUN lasts a single cycle; the behaviour is otherwise identical.
- Reset mid-operation (RUN or DONE): the operation is discarded, no out_valid is produced, and all registers return to reset values.
- Carry arithmetic: carries propagate only through the carry register, never combinationally across slices.
- Result arithmetic: sum is modulo 2^OP_W.
- Outputs during RUN: sum and cout are not meaningful; the consumer uses them only while out_valid=1.

Decomposition:
- Shared package ksa_pkg:
  - KSA_WORD_W=16;
  - state enum {IDLE, RUN, DONE};
  - localparam IDX_W = clog2(NWORDS) (minimum 1).
- Sub-module ksa16_slice:
  - thin wrapper around the existing 16-bit Kogge-Stone adder top;
  - ports: a[15:0], b[15:0], cin → s[15:0], cout;
  - purely combinational, instantiated once.
- All sequencing lives in ksa_multiword_seq.

Test Plan:
1. NWORDS=4, add, a=0x0000_0000_0000_FFFF, b=1, cin=0 → sum=0x0000_0000_0001_0000, cout=0, ovf=0; out_valid rises exactly 4 cycles after the accept edge.
2. Add, a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 → sum=0, cout=1, ovf=0. Checks the carry chain through all slices.
3. Add, a=0x7FFF_FFFF_FFFF_FFFF, b=1 → sum=0x8000_0000_0000_0000, cout=0, ovf=1.
4. Sub, a=5, b=7, cin=1 (must be ignored) → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Then sub a=7, b=5 → sum=2, cout=1.
5. Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and new operands → sum, cout, ovf stable, in_ready=0, new request not taken. After the out_ready pulse, in_ready=1 next cycle and the new request computes correctly.
6. Assert rst for 1 cycle at the 2nd RUN cycle → out_valid never asserts for that op, all outputs 0. in_ready=1 the cycle after rst deasserts. Next op a=1, b=2 → sum=3.

Source files
------------

// File: rtl/ksa_pkg.sv
// Shared types and constants for the time-multiplexed Kogge-Stone sequencer.
package ksa_pkg;

    localparam int KSA_WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice index width; a single-slice build still needs a 1-bit index.
    function automatic int ksa_idx_w(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

endpackage

// File: rtl/ksa16_slice.sv
// Combinational 16-bit Kogge-Stone adder slice with carry-in and carry-out.
module ksa16_slice
    import ksa_pkg::*;
(
    input  logic [KSA_WORD_W-1:0] a,
    input  logic [KSA_WORD_W-1:0] b,
    input  logic                  cin,
    output logic [KSA_WORD_W-1:0] s,
    output logic                  cout
);

    logic [KSA_WORD_W-1:0] p;
    logic [KSA_WORD_W-1:0] gp;
    logic [KSA_WORD_W-1:0] pp;
    logic [KSA_WORD_W-1:0] gn;
    logic [KSA_WORD_W-1:0] pn;

    always_comb begin
        p  = a ^ b;
        gp = a & b;
        // Fold the carry-in into bit 0 so the prefix tree yields every carry.
        gp[0] = gp[0] | (p[0] & cin);
        pp = p;
        gn = gp;
        pn = pp;
        for (int d = 1; d < KSA_WORD_W; d = d * 2) begin
            gn = gp;
            pn = pp;
            for (int i = d; i < KSA_WORD_W; i++) begin
                gn[i] = gp[i] | (pp[i] & gp[i-d]);
                pn[i] = pp[i] & pp[i-d];
            end
            gp = gn;
            pp = pn;
        end
        s    = p ^ {gp[KSA_WORD_W-2:0], cin};
        cout = gp[KSA_WORD_W-1];
    end

endmodule

// File: rtl/ksa_multiword_seq.sv
// Wide add/subtract sequencer: one 16-bit slice per cycle, LSB first, carry chained via a register.
// Handshake: a transfer occurs on a rising edge where valid && ready are both high on that side.
module ksa_multiword_seq
    import ksa_pkg::*;
#(
    parameter  int WORD_W = KSA_WORD_W,
    parameter  int NWORDS = 4,
    localparam int OP_W   = WORD_W * NWORDS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic            cin,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] sum,
    output logic            cout,
    output logic            ovf,
    output logic            busy,
    output state_t          state_dbg
);

    localparam int IDX_W = ksa_idx_w(NWORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic              carry;
    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   beff_q;
    logic [WORD_W-1:0] slice_a;
    logic [WORD_W-1:0] slice_b;
    logic [WORD_W-1:0] slice_s;
    logic              slice_co;
    logic              last;

    assign slice_a = a_q[idx*WORD_W +: WORD_W];
    assign slice_b = beff_q[idx*WORD_W +: WORD_W];
    assign last    = (idx == LAST_IDX);

    ksa16_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_co)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        state_dbg = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            beff_q <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        beff_q <= sub ? ~b : b;
                        carry  <= sub | cin;
                        idx    <= '0;
                    end
                end
                RUN: begin
                    sum[idx*WORD_W +: WORD_W] <= slice_s;
                    carry <= slice_co;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        cout <= slice_co;
                        // Signed overflow: like-signed operands give a result of the other sign.
                        ovf  <= (a_q[OP_W-1] == beff_q[OP_W-1]) && (slice_s[WORD_W-1] != a_q[OP_W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ksa_multiword_seq.sv
// Self-checking bench for ksa_multiword_seq with a scoreboard of expected {cout, ovf, sum}.
module tb_ksa_multiword_seq;
    import ksa_pkg::*;

    localparam int NWORDS = 4;
    localparam int OP_W   = 16 * NWORDS;
    localparam int W      = OP_W + 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [OP_W-1:0] a = '0;
    logic [OP_W-1:0] b = '0;
    logic            cin = 1'b0;
    logic            sub = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [OP_W-1:0] sum;
    logic            cout;
    logic            ovf;
    logic            busy;
    state_t          state_dbg;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_exp;
    int n_tests = 0;
    int n_fail  = 0;

    ksa_multiword_seq #(.NWORDS(NWORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [OP_W-1:0] ma, input logic [OP_W-1:0] mb,
                                           input logic mcin, input logic msub);
        logic [OP_W-1:0] beff;
        logic [OP_W:0]   full;
        logic            v;
        beff = msub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, beff} + {{OP_W{1'b0}}, (msub ? 1'b1 : mcin)};
        v    = (ma[OP_W-1] == beff[OP_W-1]) && (full[OP_W-1] != ma[OP_W-1]);
        return {full[OP_W], v, full[OP_W-1:0]};
    endfunction

    // Driver: issue one request, check latency and result; hold leaves the DUT in DONE.
    task automatic run_op(input logic [OP_W-1:0] ta, input logic [OP_W-1:0] tb_v,
                          input logic tcin, input logic tsub, input logic hold);
        int n;
        logic [W-1:0] e;
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
        check("in_ready_idle", W'(in_ready), W'(1));
        exp_q.push_back(model(ta, tb_v, tcin, tsub));
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("latency", W'(n), W'(NWORDS));
        check("busy_done", W'(busy), W'(1));
        e = exp_q.pop_front();
        last_exp = e;
        check("sum", W'(sum), W'(e[OP_W-1:0]));
        check("cout", W'(cout), W'(e[OP_W+1]));
        check("ovf", W'(ovf), W'(e[OP_W]));
        if (!hold) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            check("out_valid_drop", W'(out_valid), W'(0));
            check("in_ready_next", W'(in_ready), W'(1));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, W'(out_valid), W'(0));
        check({tag, "_sum"}, W'(sum), W'(0));
        check({tag, "_cout"}, W'(cout), W'(0));
        check({tag, "_ovf"}, W'(ovf), W'(0));
        check({tag, "_busy"}, W'(busy), W'(0));
        check({tag, "_state"}, W'(state_dbg), W'(IDLE));
    endtask

    initial begin
        int seen_valid;
        logic [OP_W-1:0] ra;
        logic [OP_W-1:0] rb;

        // Reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("in_ready_in_rst", W'(in_ready), W'(0));
        rst = 1'b0;
        #1 check_reset_state("rst");
        check("in_ready_after_rst", W'(in_ready), W'(1));

        // Directed cases
        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        run_op(64'h5, 64'h7, 1'b1, 1'b1, 1'b0);
        run_op(64'h7, 64'h5, 1'b0, 1'b1, 1'b0);
        run_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 1'b0);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 1'b0);

        // Backpressure: DONE holds while a new request is presented
        run_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, 1'b0, 1'b1);
        a = 64'hAAAA_AAAA_AAAA_AAAA; b = 64'h5555_5555_5555_5555; cin = 1'b1; sub = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_sum", W'(sum), W'(last_exp[OP_W-1:0]));
            check("bp_flags", W'({cout, ovf}), W'(last_exp[OP_W+1:OP_W]));
            check("bp_out_valid", W'(out_valid), W'(1));
            check("bp_in_ready", W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp_in_ready_after", W'(in_ready), W'(1));
        run_op(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0, 1'b0);

        // Reset during the second RUN cycle discards the operation
        @(negedge clk);
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check("in_ready_mid_rst", W'(in_ready), W'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check_reset_state("mid_rst");
        check("in_ready_post_rst", W'(in_ready), W'(1));
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 if (out_valid) seen_valid++;
        end
        check("no_valid_after_rst", W'(seen_valid), W'(0));
        run_op(64'h1, 64'h2, 1'b0, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 12; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rb = ~ra;
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        check("queue_empty", W'(exp_q.size()), W'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
